// File: rtl/regfile_np_if.sv
// regfile_np_if
//   Bus bundle for the parametrised register file.
//   master : drives write function/enables/data, read selects, bulk-clear request
//   slave  : returns read data, busy/clr_done handshake and sticky wrap flags
//   Ports: funsel[1:0], rsel[NREG-1:0], load[WIDTH-1:0], o1sel/o2sel[SELW-1:0],
//          o1/o2[WIDTH-1:0], clr_all_req, busy, clr_done, wrap[NREG-1:0]
interface regfile_np_if #(
  parameter int WIDTH = 8,
  parameter int NREG  = 8,
  parameter int SELW  = $clog2(NREG)
);
  logic [1:0]       funsel;
  logic [NREG-1:0]  rsel;
  logic [WIDTH-1:0] load;
  logic [SELW-1:0]  o1sel;
  logic [SELW-1:0]  o2sel;
  logic [WIDTH-1:0] o1;
  logic [WIDTH-1:0] o2;
  logic             clr_all_req;
  logic             busy;
  logic             clr_done;
  logic [NREG-1:0]  wrap;

  modport master (
    output funsel, rsel, load, o1sel, o2sel, clr_all_req,
    input  o1, o2, busy, clr_done, wrap
  );

  modport slave (
    input  funsel, rsel, load, o1sel, o2sel, clr_all_req,
    output o1, o2, busy, clr_done, wrap
  );
endinterface

// File: rtl/regfile_np.sv
// regfile_np
//   NREG x WIDTH register file: two combinational read ports, one shared
//   multi-register write port (clear/load/decrement/increment), sticky
//   per-register wrap flags and a one-register-per-cycle bulk-clear engine.
//   Ports: clk, rst_n (async, active low), bus (regfile_np_if.slave).
//   Optional: define REGFILE_BYPASS_EN to forward `load` onto o1/o2 in the
//   same cycle a load targets the selected register.

// One register plus its wrap flag.
module regfile_np_cell #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,      // write enable, already gated by !busy
  input  logic             clr,     // sweep clear, wins over any write
  input  logic [1:0]       funsel,
  input  logic [WIDTH-1:0] load,
  output logic [WIDTH-1:0] q,
  output logic             wrap
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      wrap <= 1'b0;
    end else if (clr) begin
      q    <= '0;
      wrap <= 1'b0;
    end else if (we) begin
      case (funsel)
        2'b00: begin q <= '0;   wrap <= 1'b0; end
        2'b01: begin q <= load; wrap <= 1'b0; end
        2'b10: begin
          q <= q - 1'b1;
          if (q == '0) wrap <= 1'b1;
        end
        default: begin
          q <= q + 1'b1;
          if (&q) wrap <= 1'b1;
        end
      endcase
    end
  end
endmodule

module regfile_np #(
  parameter  int WIDTH = 8,
  parameter  int NREG  = 8,
  localparam int SELW  = $clog2(NREG)
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_np_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t                       state, state_nxt;
  logic [SELW-1:0]              idx, idx_nxt;
  logic [NREG-1:0][WIDTH-1:0]   regs;
  logic [NREG-1:0]              wrap_q;
  logic                         busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: if (bus.clr_all_req) begin
        state_nxt = SWEEP;
        idx_nxt   = '0;
      end
      SWEEP: begin
        // idx wraps back to 0 on the last register since NREG is a power of two
        idx_nxt = idx + 1'b1;
        if (idx == SELW'(NREG - 1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy         = (state != IDLE);
  assign bus.busy     = busy;
  assign bus.clr_done = (state == DONE);
  assign bus.wrap     = wrap_q;

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    regfile_np_cell #(.WIDTH(WIDTH)) u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (!busy && bus.rsel[i]),
      .clr    ((state == SWEEP) && (idx == SELW'(i))),
      .funsel (bus.funsel),
      .load   (bus.load),
      .q      (regs[i]),
      .wrap   (wrap_q[i])
    );
  end

`ifdef REGFILE_BYPASS_EN
  logic ld_now;
  assign ld_now = !busy && (bus.funsel == 2'b01);
  assign bus.o1 = (ld_now && bus.rsel[bus.o1sel]) ? bus.load : regs[bus.o1sel];
  assign bus.o2 = (ld_now && bus.rsel[bus.o2sel]) ? bus.load : regs[bus.o2sel];
`else
  assign bus.o1 = regs[bus.o1sel];
  assign bus.o2 = regs[bus.o2sel];
`endif
endmodule

// File: doc/regfile_np.md
# regfile_np

Parametrised general-purpose register file, successor to the fixed 8×8 register file: NREG registers of WIDTH bits, two combinational read ports and one shared multi-register write port with clear/load/decrement/increment functions. It adds asynchronous reset, per-register sticky wrap flags, and a sequenced bulk-clear engine with a busy/done handshake. It sits between the ALU-input muxes and the ALU, replacing the fixed register file in the datapath.

## Interface
- WIDTH, 8, register width in bits (≥2).
- NREG, 8, register count; power of two, 2..16. Derived SELW = log2(NREG).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- funsel  in  2  write function: 00 clear, 01 load, 10 decrement, 11 increment.
- rsel  in  NREG  write enables; bit i selects register i; several bits may be set together.
- load  in  WIDTH  data for funsel=01.
- o1sel  in  SELW  read-port-1 register index.
- o2sel  in  SELW  read-port-2 register index.
- o1  out  WIDTH  contents of register o1sel.
- o2  out  WIDTH  contents of register o2sel.
- clr_all_req  in  1  one-cycle request to start a bulk clear.
- busy  out  1  high while the bulk-clear engine is active.
- clr_done  out  1  one-cycle pulse when a bulk clear completes.
- wrap  out  NREG  sticky per-register wrap flags.

## Operation
- Writes: on a clock edge with busy=0, every register i with rsel[i]=1 applies funsel. Increment and decrement are modulo 2^WIDTH.
- Increment from all-ones produces 0 and sets wrap[i]. Decrement from 0 produces all-ones and sets wrap[i]. Otherwise wrap[i] holds.
- funsel 00 or 01 on register i clears wrap[i]. Inc/dec without wrap-around leaves wrap[i] unchanged.
- Reads: o1 and o2 are combinational and independent. o1sel may equal o2sel.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE: clr_all_req=1 → SWEEP with idx=0.
  - SWEEP: each edge clears reg[idx] and wrap[idx], then increments idx. When the edge that clears idx=NREG-1 occurs, the state moves to DONE.
  - DONE: one cycle, then → IDLE.
- busy = (state≠IDLE). clr_done = (state==DONE).
- While busy=1, rsel/funsel writes are ignored and clr_all_req is ignored.
- clr_all_req together with a write in IDLE: the write is performed on that edge, and the sweep starts on the next edge.
- Reset (asynchronous, at any time, including mid-sweep):
  - all registers 0, wrap 0, state IDLE, idx 0;
  - busy 0, clr_done 0, so o1 and o2 read 0;
  - no clr_done pulse is issued for an aborted sweep.

## Timing
- Write latency: 1 edge. The new value is visible on o1/o2 after the edge.
- Bulk clear: request sampled at edge E0.
  - busy is high from E0 to E{NREG+1}, which is NREG+1 cycles.
  - Register k is cleared at edge E{k+1}.
  - clr_done is high for the single cycle between E{NREG} and E{NREG+1}.
- Registers not yet swept keep their values, and remain readable, during the sweep.

## Configuration
- REGFILE_BYPASS_EN defined:
  - o1 (o2) returns `load` combinationally when busy=0, funsel=01 and rsel[o1sel] (rsel[o2sel]) is 1.
  - The read ports therefore show the value being loaded in the same cycle.
  - No bypass applies for clear, increment or decrement.
- REGFILE_BYPASS_EN undefined: o1 and o2 always show stored contents only.

## Test plan
- Reset: rst_n low mid-cycle → all of o1/o2, wrap, busy and clr_done read 0 asynchronously.
- Multi-write and dual read: load 0xA5 with rsel=0b0000_0101, then o1sel=0, o2sel=2 → o1=o2=0xA5; reg1 still reads 0.
- Wrap flags:
  - load 0xFF into reg3, then increment → reg3=0x00 and wrap[3]=1.
  - A further increment → reg3=0x01, wrap[3] still 1.
  - load → wrap[3]=0.
  - Decrement 0 → 0xFF and wrap set.
- Bulk clear:
  - All registers loaded with 0x3C; pulse clr_all_req.
  - busy is high for 9 cycles; reg k reads 0 after E{k+1}; clr_done pulses once.
  - A write attempted while busy is ignored.
- Reset mid-sweep: assert rst_n low at E4 of a sweep → IDLE, all registers 0, no clr_done pulse. A new request after reset runs a full sweep.
- Bypass: with REGFILE_BYPASS_EN, load 0x5A into reg6 with o1sel=6 → o1=0x5A in the same cycle. Without the macro → o1 shows the old value until after the edge.
